// File: rtl/ssd_pkg.sv
// ---------------------------------------------------------------------------
// ssd_pkg
// Shared definitions for the seven-segment display reader path.
//   SEG_0..SEG_9, SEG_DASH : 7-bit {a,b,c,d,e,f,g} patterns, 0 = segment lit
//   DASH_CODE              : code reported for the dash glyph
//   ST_* / scan_state_t    : scan decoder FSM states
// ---------------------------------------------------------------------------
package ssd_pkg;

    localparam logic [6:0] SEG_0    = 7'b0000001;
    localparam logic [6:0] SEG_1    = 7'b1001111;
    localparam logic [6:0] SEG_2    = 7'b0010010;
    localparam logic [6:0] SEG_3    = 7'b0000110;
    localparam logic [6:0] SEG_4    = 7'b1001100;
    localparam logic [6:0] SEG_5    = 7'b0100100;
    localparam logic [6:0] SEG_6    = 7'b0100000;
    localparam logic [6:0] SEG_7    = 7'b0001111;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0000100;
    localparam logic [6:0] SEG_DASH = 7'b1111110;

    localparam logic [3:0] DASH_CODE = 4'hF;

    // Fixed encodings so older tooling that only knows the raw values
    // still lines up with the enum.
    localparam logic [1:0] ST_BLANK  = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_HELD   = 2'd2;

    typedef enum logic [1:0] {
        BLANK  = ST_BLANK,
        SETTLE = ST_SETTLE,
        HELD   = ST_HELD
    } scan_state_t;

endpackage

// File: rtl/ssd_pattern_decode.sv
// ---------------------------------------------------------------------------
// ssd_pattern_decode
// Combinational seven-segment pattern to BCD decoder.
//   pattern : in  7  {a..g}, active-low
//   code    : out 4  0..9, or DASH_CODE for the dash glyph; 0 when illegal
//   legal   : out 1  1 = pattern is one of the eleven known glyphs
// ---------------------------------------------------------------------------
module ssd_pattern_decode
    import ssd_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] code,
    output logic       legal
);

    always_comb begin
        code  = 4'h0;
        legal = 1'b1;
        case (pattern)
            SEG_0:    code = 4'd0;
            SEG_1:    code = 4'd1;
            SEG_2:    code = 4'd2;
            SEG_3:    code = 4'd3;
            SEG_4:    code = 4'd4;
            SEG_5:    code = 4'd5;
            SEG_6:    code = 4'd6;
            SEG_7:    code = 4'd7;
            SEG_8:    code = 4'd8;
            SEG_9:    code = 4'd9;
            SEG_DASH: code = DASH_CODE;
            default:  legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/ssd_scan_decoder.sv
// ---------------------------------------------------------------------------
// ssd_scan_decoder
// Monitors a multiplexed seven-segment bus and recovers the value shown on
// each digit position.
//   clk         : in  1            system clock
//   rst         : in  1            asynchronous active-high reset
//   anode       : in  NUM_DIGITS   digit enables, active-low
//   cathode     : in  8            {a,b,c,d,e,f,g,dp}, active-low
//   err_clr     : in  1            clears err_sticky
//   digits      : out 4*NUM_DIGITS decoded code per position
//   dp_flags    : out NUM_DIGITS   decimal point lit at last capture
//   digit_valid : out NUM_DIGITS   position holds a fresh legal decode
//   update      : out 1            pulse on every capture
//   frame_done  : out 1            pulse once every position was captured
//   err_sticky  : out 1            illegal pattern or illegal anode seen
// ---------------------------------------------------------------------------
module ssd_scan_decoder
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_DIGITS-1:0]   anode,
    input  logic [7:0]              cathode,
    input  logic                    err_clr,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   dp_flags,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    update,
    output logic                    frame_done,
    output logic                    err_sticky
);

    localparam int CNT_W  = $clog2(STABLE_CYCLES);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int LCNT_W = $clog2(NUM_DIGITS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    // ---------------- input synchronizer + previous-sample register --------
    logic [NUM_DIGITS-1:0] anode_meta_reg, anode_sample_reg, anode_prev_reg;
    logic [7:0]            cathode_meta_reg, cathode_sample_reg, cathode_prev_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            anode_meta_reg     <= '1;
            anode_sample_reg   <= '1;
            anode_prev_reg     <= '1;
            cathode_meta_reg   <= '1;
            cathode_sample_reg <= '1;
            cathode_prev_reg   <= '1;
        end else begin
            anode_meta_reg     <= anode;
            anode_sample_reg   <= anode_meta_reg;
            anode_prev_reg     <= anode_sample_reg;
            cathode_meta_reg   <= cathode;
            cathode_sample_reg <= cathode_meta_reg;
            cathode_prev_reg   <= cathode_sample_reg;
        end
    end

    // ---------------- anode classification --------------------------------
    logic [LCNT_W-1:0] low_count;
    logic [IDX_W-1:0]  low_index;
    logic              one_low;
    logic              multi_low;
    logic              changed;

    always_comb begin
        low_count = '0;
        low_index = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!anode_sample_reg[i]) begin
                low_count = low_count + LCNT_W'(1);
                low_index = IDX_W'(i);
            end
        end
    end

    assign one_low   = (low_count == LCNT_W'(1));
    assign multi_low = (low_count > LCNT_W'(1));
    assign changed   = (anode_sample_reg != anode_prev_reg) ||
                       (cathode_sample_reg != cathode_prev_reg);

    // ---------------- pattern decode --------------------------------------
    logic [3:0] dec_code;
    logic       dec_legal;

    ssd_pattern_decode u_decode (
        .pattern (cathode_sample_reg[7:1]),
        .code    (dec_code),
        .legal   (dec_legal)
    );

    // ---------------- settle FSM ------------------------------------------
    scan_state_t      state_reg, state_next;
    logic [CNT_W-1:0] stab_cnt_reg, stab_cnt_next;
    logic             capture;

    always_comb begin
        state_next    = state_reg;
        stab_cnt_next = stab_cnt_reg;
        capture       = 1'b0;
        if (!one_low) begin
            // Blank and multi-low anodes both park the FSM in BLANK.
            state_next    = BLANK;
            stab_cnt_next = '0;
        end else if (changed || state_reg == BLANK) begin
            state_next    = SETTLE;
            stab_cnt_next = '0;
        end else if (state_reg == SETTLE) begin
            if (stab_cnt_reg == CNT_LAST) begin
                capture    = 1'b1;
                state_next = HELD;
            end else begin
                stab_cnt_next = stab_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= BLANK;
            stab_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            stab_cnt_reg <= stab_cnt_next;
        end
    end

    // ---------------- per-position storage and timeout --------------------
    logic [NUM_DIGITS-1:0] cap_mask;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_pos
            logic [3:0]      digit_reg;
            logic            dp_reg;
            logic            valid_reg;
            logic [TO_W-1:0] age_reg;

            assign cap_mask[gi] = capture && (low_index == IDX_W'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    digit_reg <= '0;
                    dp_reg    <= 1'b0;
                    valid_reg <= 1'b0;
                    age_reg   <= '0;
                end else if (cap_mask[gi] && dec_legal) begin
                    // A legal capture wins over a timeout landing this cycle.
                    digit_reg <= dec_code;
                    dp_reg    <= ~cathode_sample_reg[0];
                    valid_reg <= 1'b1;
                    age_reg   <= '0;
                end else begin
                    if (age_reg != TO_MAX) begin
                        age_reg <= age_reg + 1'b1;
                    end
                    // Clear on the cycle the age reaches TIMEOUT_CYCLES.
                    if (cap_mask[gi] || age_reg >= TO_LAST) begin
                        valid_reg <= 1'b0;
                    end
                end
            end

            assign digits[4*gi +: 4] = digit_reg;
            assign dp_flags[gi]      = dp_reg;
            assign digit_valid[gi]   = valid_reg;
        end
    endgenerate

    // ---------------- status pulses and sticky error ----------------------
    logic [NUM_DIGITS-1:0] seen_reg;
    logic                  err_set;

    assign err_set = multi_low || (capture && !dec_legal);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen_reg   <= '0;
            update     <= 1'b0;
            frame_done <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            update <= capture;
            if (&seen_reg) begin
                // Restart the frame immediately; a capture here counts
                // towards the next one.
                frame_done <= 1'b1;
                seen_reg   <= cap_mask;
            end else begin
                frame_done <= 1'b0;
                seen_reg   <= seen_reg | cap_mask;
            end
            if (err_set) begin
                err_sticky <= 1'b1;
            end else if (err_clr) begin
                err_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: doc/ssd_scan_decoder.md
Name: ssd_scan_decoder

Overview:
- Reader side of the multiplexed seven-segment display interface.
- Samples the shared `anode` and `cathode` lines, waits for each digit slot to settle, then decodes the segment pattern back to a BCD code.
- Holds one decoded value per digit position, with valid, decimal-point and error status.
- Used as a display-bus monitor and as a loopback checker for the on-board display path.

Parameters:
- NUM_DIGITS, 4: number of anode lines / digit positions.
- STABLE_CYCLES, 16: consecutive identical samples required before a capture (min 2).
- TIMEOUT_CYCLES, 1048576: cycles without a capture before a position's valid bit clears.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- anode  in  NUM_DIGITS  digit enables, active-low; exactly one low selects a position.
- cathode  in  8  segments {a,b,c,d,e,f,g,dp}, active-low; a = bit 7, g = bit 1, dp = bit 0.
- err_clr  in  1  clears err_sticky.
- digits  out  4*NUM_DIGITS  decoded codes; position i occupies bits [4i+3:4i].
- dp_flags  out  NUM_DIGITS  1 = decimal point lit at the last capture of that position.
- digit_valid  out  NUM_DIGITS  1 = position holds a fresh, legal decode.
- update  out  1  one-cycle pulse on every capture.
- frame_done  out  1  one-cycle pulse when every position has been captured since the last pulse.
- err_sticky  out  1  set on an illegal pattern or an illegal anode; cleared by err_clr.

Behaviour:
- Reset values:
  - digits = 0, dp_flags = 0, digit_valid = 0.
  - update = 0, frame_done = 0, err_sticky = 0.
  - sync/history registers = all ones (blank); FSM = BLANK; seen mask = 0; all timeout counters = 0.
- Reset mid-operation returns every register to the values above immediately; no partial capture survives.
- Input conditioning:
  - anode and cathode pass through a 2-flop synchronizer.
  - "Sample" below means the second-stage value; a third register holds the previous sample.
- Decode table (7-bit {a..g}, 0 = lit):
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4
  - 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9
  - 1111110 (dash) → 4'hF
  - Any other pattern is illegal.
- FSM states and transitions:
  - BLANK: anode sample is all ones. Stability counter held 0; no error.
  - SETTLE: exactly one anode low. The counter increments while the sample equals the previous sample and reloads to 0 on any change in anode or cathode. When it reaches STABLE_CYCLES-1, perform a capture and go to HELD.
  - HELD: no further capture until the sample changes.
    - Change to another legal slot or pattern → SETTLE (counter 0).
    - Change to all-ones anode → BLANK.
  - Multiple anodes low, from any state: treated as BLANK for capture purposes, and err_sticky is set.
- Capture of position i with a legal pattern:
  - digits[i] = code, dp_flags[i] = ~cathode[0], digit_valid[i] = 1.
  - update pulses, seen[i] = 1, timeout counter i reloads to 0.
- Capture of position i with an illegal pattern:
  - digits[i] unchanged, digit_valid[i] = 0, err_sticky = 1.
  - update still pulses, seen[i] = 1.
- Latency: input edge to updated outputs = 2 (sync) + STABLE_CYCLES + 1 cycles. With defaults this is 19; all outputs are registered.
- frame_done:
  - Asserts the cycle after seen reaches all ones.
  - seen clears in the same cycle, so the next frame starts counting at once.
- Timeout:
  - Each position's counter saturates at TIMEOUT_CYCLES.
  - On reaching it, digit_valid[i] = 0; digits[i] and dp_flags[i] are retained.
  - A capture in that same cycle wins: valid stays 1 and the counter reloads.
- err_clr:
  - Clears err_sticky the next cycle.
  - If a new error occurs in the same cycle, set wins.
- Width rules:
  - Stability counter width = clog2(STABLE_CYCLES).
  - Timeout counter width = clog2(TIMEOUT_CYCLES+1).
  - No wrap-around: both counters saturate.

Decomposition:
- Package ssd_pkg holds:
  - SEG_0..SEG_9 and SEG_DASH 7-bit constants.
  - DASH_CODE = 4'hF.
  - The FSM state enum {BLANK, SETTLE, HELD}.
- One sub-module: ssd_pattern_decode, combinational. Input is the 7-bit pattern; outputs are the 4-bit code and a legal flag. It is shared with the display-path checkers.

Test Plan:
- Reset then idle with anode = 4'b1111 for 100 cycles → all outputs 0, no update, no error.
- Hold anode = 4'b1110 and cathode = 8'b0010010_0 for 19 cycles → digits[3:0] = 2, dp_flags[0] = 1, digit_valid[0] = 1, update is a single pulse exactly 19 cycles after the edge.
- Scan positions 0..3 with 3, 9, 0, dash (40 cycles each, no dp) → digits = 16'hF093, digit_valid = 4'b1111, one frame_done pulse after position 3's capture.
- Glitch the cathode for 1 cycle at cycle 10 of a slot → counter restarts, capture occurs 16 cycles after the glitch ends, never on the glitched value.
- Drive illegal pattern 8'b1010101_1 on position 1 → err_sticky = 1, digit_valid[1] = 0, digits[7:4] retains its prior value. Then assert err_clr while anode = 4'b1100 → err_sticky stays 1 (set wins).
- With TIMEOUT_CYCLES = 64, capture position 2 then blank the display → digit_valid[2] clears exactly 64 cycles after that capture and digits[11:8] is unchanged. Separately, assert rst mid-SETTLE → all outputs 0 asynchronously and no capture follows.
